// File: rtl/score_pkg.sv
// Shared types and BCD helpers for the collision score keeper.
package score_pkg;

    typedef enum logic [1:0] {IDLE, PLAY, COOLDOWN, GAME_OVER} game_state_t;

    typedef logic [3:0] bcd_t;
    localparam bcd_t BCD_MAX = 4'd9;

    function automatic bcd_t bcd_step(input bcd_t d, input logic clr, input logic inc);
        if (clr) return '0;
        if (inc) return (d == BCD_MAX) ? '0 : d + 4'd1;
        return d;
    endfunction

    // Blank every zero digit above the ones digit that has no non-zero digit above it.
    function automatic logic [3:0] lead_zero_mask(input logic [15:0] s);
        logic [3:0] m;
        m    = '0;
        m[3] = (s[15:12] == 4'd0);
        m[2] = m[3] && (s[11:8] == 4'd0);
        m[1] = m[2] && (s[7:4] == 4'd0);
        return m;
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One decimal digit of the score: synchronous clear, increment with wrap 9->0 and carry out.
module bcd_digit_counter
    import score_pkg::*;
(
    input  logic clk,
    input  logic resetN,
    input  logic clr,
    input  logic inc,
    output bcd_t digit,
    output logic carry
);

    bcd_t digit_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) digit_q <= '0;
        else         digit_q <= bcd_step(digit_q, clr, inc);
    end

    assign digit = digit_q;
    assign carry = inc && (digit_q == BCD_MAX);

endmodule

// File: rtl/collision_score_keeper.sv
// Frame-synchronous hit/lives/score bookkeeping feeding the HEX displays.
// Optional game-over score blink is enabled by defining SCORE_BLINK_EN.
module collision_score_keeper
    import score_pkg::*;
#(
    parameter int unsigned LIVES            = 3,
    parameter int unsigned FRAMES_PER_POINT = 60,
    parameter int unsigned COOLDOWN_FRAMES  = 90,
    parameter int unsigned BLINK_FRAMES     = 30
)(
    input  logic        clk,
    input  logic        resetN,
    input  logic        collision,
    input  logic        start,
    input  logic [31:0] pxl_x,
    input  logic [31:0] pxl_y,
    output logic [15:0] score_bcd,
    output logic [3:0]  digit_off,
    output logic [1:0]  lives,
    output logic        hit_pulse,
    output logic        game_over
);

    localparam int unsigned PT_W = $clog2(FRAMES_PER_POINT + 1);
    localparam int unsigned CD_W = $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [PT_W-1:0] PT_LAST = PT_W'(FRAMES_PER_POINT - 1);
    localparam logic [CD_W-1:0] CD_LAST = CD_W'(COOLDOWN_FRAMES - 1);

    game_state_t     state_q;
    logic            sof_q, start_q, hit_seen_q;
    logic [PT_W-1:0] pt_cnt_q;
    logic [CD_W-1:0] cd_cnt_q;
    logic [1:0]      lives_q;
    logic            hit_pulse_q, game_over_q;
    logic [3:0]      digit_off_q;

    logic        at_origin, sof, start_rise, reload, pt_run, pt_wrap;
    logic        score_max, in_game_d, hit_seen_d, blank_all;
    logic [3:0]  inc;
    logic [2:0]  carry;
    logic        unused_top_carry;
    bcd_t        dig [4];
    logic [15:0] score_d;

    assign at_origin  = (pxl_x == '0) && (pxl_y == '0);
    assign sof        = at_origin && !sof_q;
    assign start_rise = start && !start_q;
    assign reload     = start_rise && (state_q == IDLE || state_q == GAME_OVER);
    assign pt_run     = sof && (state_q == COOLDOWN || (state_q == PLAY && !hit_seen_q));
    assign pt_wrap    = pt_run && (pt_cnt_q == PT_LAST);
    assign score_max  = (score_bcd == 16'h9999);
    assign inc[0]     = pt_wrap && !score_max;
    assign inc[3:1]   = carry;
    // A collision on the sof cycle belongs to the frame that is just starting.
    assign hit_seen_d = collision || (hit_seen_q && !sof);
    assign in_game_d  = (state_q != IDLE) || reload;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sof_q      <= 1'b0;
            start_q    <= 1'b0;
            hit_seen_q <= 1'b0;
        end else begin
            sof_q      <= at_origin;
            start_q    <= start;
            hit_seen_q <= hit_seen_d;
        end
    end

    bcd_digit_counter u_ones (.clk(clk), .resetN(resetN), .clr(reload), .inc(inc[0]), .digit(dig[0]), .carry(carry[0]));
    bcd_digit_counter u_tens (.clk(clk), .resetN(resetN), .clr(reload), .inc(inc[1]), .digit(dig[1]), .carry(carry[1]));
    bcd_digit_counter u_hund (.clk(clk), .resetN(resetN), .clr(reload), .inc(inc[2]), .digit(dig[2]), .carry(carry[2]));
    bcd_digit_counter u_thou (.clk(clk), .resetN(resetN), .clr(reload), .inc(inc[3]), .digit(dig[3]), .carry(unused_top_carry));

    assign score_bcd = {dig[3], dig[2], dig[1], dig[0]};
    assign score_d   = {bcd_step(dig[3], reload, inc[3]), bcd_step(dig[2], reload, inc[2]),
                        bcd_step(dig[1], reload, inc[1]), bcd_step(dig[0], reload, inc[0])};

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            pt_cnt_q    <= '0;
            cd_cnt_q    <= '0;
            lives_q     <= '0;
            hit_pulse_q <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            hit_pulse_q <= 1'b0;
            if (reload) begin
                state_q     <= PLAY;
                pt_cnt_q    <= '0;
                cd_cnt_q    <= '0;
                lives_q     <= 2'(LIVES);
                game_over_q <= 1'b0;
            end else if (sof) begin
                case (state_q)
                    PLAY: begin
                        if (hit_seen_q) begin
                            hit_pulse_q <= 1'b1;
                            lives_q     <= lives_q - 2'd1;
                            if (lives_q == 2'd1) begin
                                state_q     <= GAME_OVER;
                                game_over_q <= 1'b1;
                            end else begin
                                state_q  <= COOLDOWN;
                                cd_cnt_q <= '0;
                            end
                        end else begin
                            pt_cnt_q <= pt_wrap ? '0 : pt_cnt_q + PT_W'(1);
                        end
                    end
                    COOLDOWN: begin
                        pt_cnt_q <= pt_wrap ? '0 : pt_cnt_q + PT_W'(1);
                        if (cd_cnt_q == CD_LAST) begin
                            cd_cnt_q <= '0;
                            state_q  <= PLAY;
                        end else begin
                            cd_cnt_q <= cd_cnt_q + CD_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SCORE_BLINK_EN
    localparam int unsigned BK_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [BK_W-1:0] BK_LAST = BK_W'(BLINK_FRAMES - 1);

    logic [BK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic            blink_q, blink_d;

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        blink_d   = blink_q;
        if (state_q != GAME_OVER || reload) begin
            blk_cnt_d = '0;
            blink_d   = 1'b0;
        end else if (sof) begin
            if (blk_cnt_q == BK_LAST) begin
                blk_cnt_d = '0;
                blink_d   = !blink_q;
            end else begin
                blk_cnt_d = blk_cnt_q + BK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            blk_cnt_q <= '0;
            blink_q   <= 1'b0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
            blink_q   <= blink_d;
        end
    end

    assign blank_all = blink_d;
`else
    logic unused_blink_cfg;
    assign unused_blink_cfg = ^BLINK_FRAMES;
    assign blank_all        = 1'b0;
`endif

    // Mask is derived from the next score so it lands in the same cycle as score_bcd.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)        digit_off_q <= '0;
        else if (blank_all) digit_off_q <= '1;
        else if (in_game_d) digit_off_q <= lead_zero_mask(score_d);
        else                digit_off_q <= '0;
    end

    assign digit_off = digit_off_q;
    assign lives     = lives_q;
    assign hit_pulse = hit_pulse_q;
    assign game_over = game_over_q;

endmodule
